// File: rtl/img_move_ctrl_if.sv
// Control/status bundle between the frame timing source and img_move_ctrl.
// The master drives frame/run/recenter; the slave reports position and status.
interface img_move_ctrl_if;
  logic        frame_begin;
  logic        run;
  logic        recenter;
  logic [15:0] img_disp_hbegin;
  logic [15:0] img_disp_vbegin;
  logic        h_dir;
  logic        v_dir;
  logic        pos_update;
  logic [15:0] edge_hit_cnt;

  modport master (
    output frame_begin, run, recenter,
    input  img_disp_hbegin, img_disp_vbegin, h_dir, v_dir, pos_update, edge_hit_cnt
  );

  modport slave (
    input  frame_begin, run, recenter,
    output img_disp_hbegin, img_disp_vbegin, h_dir, v_dir, pos_update, edge_hit_cnt
  );
endinterface

// File: rtl/img_move_ctrl.sv
// Bouncing image position controller, updated once per FRAME_DIV frames.
// Optional wall-hit counter is built only when EDGE_HIT_CNT_EN is defined.
module img_move_ctrl #(
  parameter int H_Visible_area = 800,
  parameter int V_Visible_area = 480,
  parameter int IMG_WIDTH      = 200,
  parameter int IMG_HEIGHT     = 200,
  parameter int STEP           = 4,
  parameter int FRAME_DIV      = 1
) (
  input logic            clk_ctrl,
  input logic            rst,
  img_move_ctrl_if.slave bus
);

  localparam int HMAX_I = (H_Visible_area > IMG_WIDTH)  ? H_Visible_area - IMG_WIDTH  : 0;
  localparam int VMAX_I = (V_Visible_area > IMG_HEIGHT) ? V_Visible_area - IMG_HEIGHT : 0;
  localparam logic [15:0] HMAX      = 16'(HMAX_I);
  localparam logic [15:0] VMAX      = 16'(VMAX_I);
  localparam logic [15:0] HC        = 16'(HMAX_I / 2);
  localparam logic [15:0] VC        = 16'(VMAX_I / 2);
  localparam logic [15:0] STEP16    = 16'(STEP);
  localparam logic [7:0]  FDIV_LAST = 8'(FRAME_DIV - 1);

  typedef enum logic [1:0] {IDLE, CALC_H, CALC_V, COMMIT} state_t;

  typedef struct packed {
    logic [15:0] pos;
    logic        dir;
  } axis_t;

  // One axis of motion; the 17-bit sum keeps pos + STEP from wrapping.
  function automatic axis_t axis_next(input logic [15:0] pos, input logic dir,
                                      input logic [15:0] maxv, input logic [15:0] ctr,
                                      input logic rc, input logic en);
    axis_t       r;
    logic [16:0] sum;
    r.pos = pos;
    r.dir = dir;
    sum   = {1'b0, pos} + {1'b0, STEP16};
    if (rc) begin
      r.pos = ctr;
    end else if (en) begin
      if (maxv == 16'd0) begin
        r.pos = 16'd0;
      end else if (dir) begin
        if (sum >= {1'b0, maxv}) begin
          r.pos = maxv;
          r.dir = 1'b0;
        end else begin
          r.pos = sum[15:0];
        end
      end else begin
        if (pos <= STEP16) begin
          r.pos = 16'd0;
          r.dir = 1'b1;
        end else begin
          r.pos = pos - STEP16;
        end
      end
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  fdiv_q, fdiv_d;
  logic        rc_pend_q, rc_pend_d;
  logic        rc_used_q, rc_used_d;
  logic [15:0] nh_q, nh_d;
  logic        nh_dir_q, nh_dir_d;
  logic [15:0] hbegin_q, hbegin_d;
  logic [15:0] vbegin_q, vbegin_d;
  logic        h_dir_q, h_dir_d;
  logic        v_dir_q, v_dir_d;
  logic        rc_now;
  axis_t       ax_h, ax_v;

  // A recenter arriving during CALC_H is honoured by the update in progress.
  assign rc_now = rc_pend_q | bus.recenter;
  assign ax_h   = axis_next(hbegin_q, h_dir_q, HMAX, HC, rc_now, bus.run);
  assign ax_v   = axis_next(vbegin_q, v_dir_q, VMAX, VC, rc_used_q, bus.run);

  always_comb begin
    state_d   = state_q;
    fdiv_d    = fdiv_q;
    rc_pend_d = rc_now;
    rc_used_d = rc_used_q;
    nh_d      = nh_q;
    nh_dir_d  = nh_dir_q;
    hbegin_d  = hbegin_q;
    vbegin_d  = vbegin_q;
    h_dir_d   = h_dir_q;
    v_dir_d   = v_dir_q;
    case (state_q)
      IDLE: begin
        if (bus.frame_begin) begin
          if (fdiv_q == FDIV_LAST) begin
            fdiv_d  = 8'd0;
            state_d = CALC_H;
          end else begin
            fdiv_d = fdiv_q + 8'd1;
          end
        end
      end
      CALC_H: begin
        nh_d      = ax_h.pos;
        nh_dir_d  = ax_h.dir;
        rc_used_d = rc_now;
        if (rc_now) rc_pend_d = 1'b0;
        state_d   = CALC_V;
      end
      CALC_V: begin
        // All outputs load together on the edge that enters COMMIT.
        hbegin_d = nh_q;
        h_dir_d  = nh_dir_q;
        vbegin_d = ax_v.pos;
        v_dir_d  = ax_v.dir;
        state_d  = COMMIT;
      end
      COMMIT: begin
        rc_used_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_ctrl) begin
    if (!rst) begin
      state_q   <= IDLE;
      fdiv_q    <= 8'd0;
      rc_pend_q <= 1'b0;
      rc_used_q <= 1'b0;
      nh_q      <= HC;
      nh_dir_q  <= 1'b1;
      hbegin_q  <= HC;
      vbegin_q  <= VC;
      h_dir_q   <= 1'b1;
      v_dir_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      fdiv_q    <= fdiv_d;
      rc_pend_q <= rc_pend_d;
      rc_used_q <= rc_used_d;
      nh_q      <= nh_d;
      nh_dir_q  <= nh_dir_d;
      hbegin_q  <= hbegin_d;
      vbegin_q  <= vbegin_d;
      h_dir_q   <= h_dir_d;
      v_dir_q   <= v_dir_d;
    end
  end

  assign bus.img_disp_hbegin = hbegin_q;
  assign bus.img_disp_vbegin = vbegin_q;
  assign bus.h_dir           = h_dir_q;
  assign bus.v_dir           = v_dir_q;
  assign bus.pos_update      = (state_q == COMMIT);

`ifdef EDGE_HIT_CNT_EN
  logic [15:0] edge_cnt_q, edge_cnt_d;
  logic [1:0]  hits;
  logic [16:0] cnt_sum;

  // A direction flip at the commit edge is one wall hit; a corner gives two.
  always_comb begin
    hits = 2'd0;
    if (state_q == CALC_V) begin
      hits = {1'b0, nh_dir_q != h_dir_q} + {1'b0, ax_v.dir != v_dir_q};
    end
    cnt_sum    = {1'b0, edge_cnt_q} + {15'd0, hits};
    edge_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk_ctrl) begin
    if (!rst) edge_cnt_q <= 16'd0;
    else      edge_cnt_q <= edge_cnt_d;
  end

  assign bus.edge_hit_cnt = edge_cnt_q;
`else
  assign bus.edge_hit_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_img_move_ctrl.sv
// Scoreboard bench for img_move_ctrl: instance A uses defaults, instance B has
// HMAX=0, STEP=3, FRAME_DIV=3. Expected positions come from a bench-side model.
module tb_img_move_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  img_move_ctrl_if bus_a();
  img_move_ctrl_if bus_b();

  img_move_ctrl dut_a (.clk_ctrl(clk), .rst(rst), .bus(bus_a));
  img_move_ctrl #(.IMG_WIDTH(900), .STEP(3), .FRAME_DIV(3)) dut_b (.clk_ctrl(clk), .rst(rst), .bus(bus_b));

  localparam int M_HMAX [2] = '{600, 0};
  localparam int M_VMAX [2] = '{280, 280};
  localparam int M_STEP [2] = '{4, 3};
  localparam int M_FDIV [2] = '{1, 3};
`ifdef EDGE_HIT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    int h;
    int v;
    bit hd;
    bit vd;
    int cnt;
    int cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   m_h[2], m_v[2], m_cnt[2], m_fdiv[2];
  bit   m_hd[2], m_vd[2], m_rc[2];
  int   last_h[2], last_v[2];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_h[i]    = M_HMAX[i] / 2;
      m_v[i]    = M_VMAX[i] / 2;
      m_hd[i]   = 1'b1;
      m_vd[i]   = 1'b1;
      m_cnt[i]  = 0;
      m_fdiv[i] = 0;
      m_rc[i]   = 1'b0;
      last_h[i] = m_h[i];
      last_v[i] = m_v[i];
    end
  endtask

  task automatic axis(input int mx, input int st, inout int p, inout bit d, inout int hits);
    if (mx == 0) begin
      p = 0;
    end else if (d) begin
      p = p + st;
      if (p >= mx) begin p = mx; d = 1'b0; hits++; end
    end else begin
      p = p - st;
      if (p <= 0) begin p = 0; d = 1'b1; hits++; end
    end
  endtask

  task automatic model_frame(input int i, input bit run_now, input bit rc_now, output bit upd);
    exp_t e;
    int   hits = 0;
    int   h = m_h[i], v = m_v[i];
    bit   hd = m_hd[i], vd = m_vd[i];
    upd = 1'b0;
    if (m_fdiv[i] + 1 < M_FDIV[i]) begin
      m_fdiv[i]++;
      return;
    end
    m_fdiv[i] = 0;
    upd = 1'b1;
    if (m_rc[i] || rc_now) begin
      h = M_HMAX[i] / 2;
      v = M_VMAX[i] / 2;
      m_rc[i] = 1'b0;
    end else if (run_now) begin
      axis(M_HMAX[i], M_STEP[i], h, hd, hits);
      axis(M_VMAX[i], M_STEP[i], v, vd, hits);
    end
    m_h[i] = h; m_v[i] = v; m_hd[i] = hd; m_vd[i] = vd;
    m_cnt[i] = (m_cnt[i] + hits > 65535) ? 65535 : m_cnt[i] + hits;
    e.h = h; e.v = v; e.hd = hd; e.vd = vd;
    e.cnt = CNT_EN ? m_cnt[i] : 0;
    e.cyc = cyc + 3;
    if (i == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic mon(input int i, input logic [15:0] h, input logic [15:0] v, input logic hd,
                     input logic vd, input logic [15:0] cnt, input logic pu);
    exp_t  e;
    string n = (i == 0) ? "a" : "b";
    if (!pu) begin
      check_eq({n, "_hold"}, {h, v}, {16'(last_h[i]), 16'(last_v[i])});
      return;
    end
    if ((i == 0 ? q_a.size() : q_b.size()) == 0) begin
      check_eq({n, "_spurious_update"}, 0, 1);
      return;
    end
    e = (i == 0) ? q_a.pop_front() : q_b.pop_front();
    $display("%s update h=%0d v=%0d hd=%0b vd=%0b cnt=%0d cyc=%0d", n, h, v, hd, vd, cnt, cyc);
    check_eq({n, "_hbegin"}, 32'(h), e.h);
    check_eq({n, "_vbegin"}, 32'(v), e.v);
    check_eq({n, "_h_dir"}, 32'(hd), 32'(e.hd));
    check_eq({n, "_v_dir"}, 32'(vd), 32'(e.vd));
    check_eq({n, "_edge_cnt"}, 32'(cnt), e.cnt);
    check_eq({n, "_latency"}, cyc, e.cyc);
    last_h[i] = e.h;
    last_v[i] = e.v;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0, bus_a.img_disp_hbegin, bus_a.img_disp_vbegin, bus_a.h_dir, bus_a.v_dir,
          bus_a.edge_hit_cnt, bus_a.pos_update);
      mon(1, bus_b.img_disp_hbegin, bus_b.img_disp_vbegin, bus_b.h_dir, bus_b.v_dir,
          bus_b.edge_hit_cnt, bus_b.pos_update);
    end
  end

  // Called #1 after a posedge; the reset is sampled on the following edge.
  task automatic apply_reset();
    rst = 1'b0;
    q_a.delete();
    q_b.delete();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic check_reset_state();
    check_eq("rst_a_h", bus_a.img_disp_hbegin, 300);
    check_eq("rst_a_v", bus_a.img_disp_vbegin, 140);
    check_eq("rst_a_hd", bus_a.h_dir, 1);
    check_eq("rst_a_vd", bus_a.v_dir, 1);
    check_eq("rst_a_pu", bus_a.pos_update, 0);
    check_eq("rst_a_cnt", bus_a.edge_hit_cnt, 0);
    check_eq("rst_b_h", bus_b.img_disp_hbegin, 0);
    check_eq("rst_b_v", bus_b.img_disp_vbegin, 140);
    check_eq("rst_b_hd", bus_b.h_dir, 1);
    check_eq("rst_b_vd", bus_b.v_dir, 1);
    check_eq("rst_b_pu", bus_b.pos_update, 0);
    check_eq("rst_b_cnt", bus_b.edge_hit_cnt, 0);
  endtask

  task automatic drain();
    int k = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && k < 20) begin
      @(posedge clk);
      k++;
    end
    if (q_a.size() + q_b.size() != 0) begin
      check_eq("update_timeout", q_a.size() + q_b.size(), 0);
      q_a.delete();
      q_b.delete();
    end
  endtask

  task automatic set_fb(input int i, input logic val);
    if (i == 0) bus_a.frame_begin = val;
    else        bus_b.frame_begin = val;
  endtask

  task automatic set_rc(input int i, input logic val);
    if (i == 0) bus_a.recenter = val;
    else        bus_b.recenter = val;
  endtask

  task automatic send_frame(input int i, input bit rc_calc = 1'b0, input bit dbl = 1'b0);
    bit upd;
    bit r;
    @(posedge clk); #1;
    set_fb(i, 1'b1);
    r = (i == 0) ? bus_a.run : bus_b.run;
    model_frame(i, r, rc_calc, upd);
    @(posedge clk); #1;
    if (dbl) begin
      if (!upd) model_frame(i, r, 1'b0, upd);
      @(posedge clk); #1;
    end
    set_fb(i, 1'b0);
    if (rc_calc) begin
      if (!upd) m_rc[i] = 1'b1;
      set_rc(i, 1'b1);
      @(posedge clk); #1;
      set_rc(i, 1'b0);
    end
    drain();
  endtask

  task automatic pulse_recenter(input int i);
    @(posedge clk); #1;
    set_rc(i, 1'b1);
    m_rc[i] = 1'b1;
    @(posedge clk); #1;
    set_rc(i, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus_a.frame_begin = 1'b0; bus_a.run = 1'b0; bus_a.recenter = 1'b0;
    bus_b.frame_begin = 1'b0; bus_b.run = 1'b0; bus_b.recenter = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    apply_reset();
    check_reset_state();

    // Paused: pos_update still pulses, position stays put.
    for (int k = 0; k < 10; k++) send_frame(0);
    check_eq("paused_h", bus_a.img_disp_hbegin, 300);
    check_eq("paused_v", bus_a.img_disp_vbegin, 140);

    bus_a.run = 1'b1;
    send_frame(0);
    check_eq("first_move_h", bus_a.img_disp_hbegin, 304);
    check_eq("first_move_v", bus_a.img_disp_vbegin, 144);

    // Update 525 is a corner hit from (4,4) moving up-left.
    for (int k = 0; k < 524; k++) send_frame(0);
    check_eq("corner_h", bus_a.img_disp_hbegin, 0);
    check_eq("corner_v", bus_a.img_disp_vbegin, 0);
    check_eq("corner_hd", bus_a.h_dir, 1);
    check_eq("corner_vd", bus_a.v_dir, 1);

    for (int k = 0; k < 20; k++) send_frame(0);
    pulse_recenter(0);
    repeat (3) @(posedge clk);
    send_frame(0);
    check_eq("recenter_h", bus_a.img_disp_hbegin, 300);
    check_eq("recenter_v", bus_a.img_disp_vbegin, 140);

    for (int k = 0; k < 5; k++) send_frame(0);
    send_frame(0, 1'b1);
    check_eq("recenter_calc_h", bus_a.img_disp_hbegin, 300);
    check_eq("recenter_calc_v", bus_a.img_disp_vbegin, 140);

    // Divided instance with a doubled pulse on each accepted frame.
    bus_b.run = 1'b1;
    for (int g = 0; g < 4; g++) begin
      send_frame(1);
      send_frame(1);
      send_frame(1, 1'b0, 1'b1);
    end
    check_eq("div_b_h", bus_b.img_disp_hbegin, 0);
    check_eq("div_b_v", bus_b.img_disp_vbegin, 152);
    for (int k = 0; k < 150; k++) send_frame(1);

    // Reset while dut_a sits in CALC_V drops the pending update.
    @(posedge clk); #1;
    bus_a.frame_begin = 1'b1;
    begin
      bit upd;
      model_frame(0, bus_a.run, 1'b0, upd);
    end
    @(posedge clk); #1;
    bus_a.frame_begin = 1'b0;
    @(posedge clk); #1;
    apply_reset();
    check_reset_state();
    repeat (10) @(posedge clk);
    send_frame(0);
    check_eq("post_reset_h", bus_a.img_disp_hbegin, 304);
    check_eq("post_reset_v", bus_a.img_disp_vbegin, 144);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/img_move_ctrl.md
Name: img_move_ctrl

Overview:
- Frame-synchronous position controller for the image extraction datapath.
- Generates `img_disp_hbegin` and `img_disp_vbegin` so that the image bounces off the edges of the visible area, moving STEP pixels per update.
- Updates only right after `frame_begin`, so the position is stable for the whole visible frame.
- Supports run/pause, a frame-rate divider and recentring.

Parameters:
- H_Visible_area, 800: visible width in pixels.
- V_Visible_area, 480: visible height in lines.
- IMG_WIDTH, 200: image width.
- IMG_HEIGHT, 200: image height.
- STEP, 4: pixels moved per update on each axis (1..255).
- FRAME_DIV, 1: number of frames per position update (1..255).

Ports:
- clk_ctrl  in  1  clock, same as the TFT pixel clock.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- frame_begin  in  1  one-cycle frame start pulse.
- run  in  1  1 = motion enabled, 0 = position frozen.
- recenter  in  1  one-cycle request; the image returns to centre at the next update slot.
- img_disp_hbegin  out  16  image top-left column.
- img_disp_vbegin  out  16  image top-left row.
- h_dir  out  1  1 = moving right, 0 = moving left.
- v_dir  out  1  1 = moving down, 0 = moving up.
- pos_update  out  1  one-cycle pulse when the new position is committed.
- edge_hit_cnt  out  16  wall-hit counter (optional feature).

Behaviour:
- Derived constants:
  - HMAX = H_Visible_area - IMG_WIDTH, or 0 if negative.
  - VMAX = V_Visible_area - IMG_HEIGHT, or 0 if negative.
  - HC = HMAX/2, VC = VMAX/2 (floor).
- Reset values (rst=0 sampled at a clk_ctrl edge):
  - hbegin = HC, vbegin = VC.
  - h_dir = 1, v_dir = 1.
  - pos_update = 0, edge_hit_cnt = 0.
  - frame divider = 0, recenter_pend = 0, state = IDLE.
- Reset mid-update aborts the update; no partial position is kept.
- `recenter` is latched into recenter_pend in any state. It is cleared when consumed at the next update slot.
- Frame divider (fdiv):
  - In IDLE, each `frame_begin` increments fdiv.
  - When fdiv == FRAME_DIV-1, fdiv returns to 0 and the controller moves to CALC_H. Otherwise it stays in IDLE.
  - The divider counts regardless of `run`.
- State machine (states IDLE, CALC_H, CALC_V, COMMIT, one cycle each except IDLE):
  - IDLE: wait as described above.
  - CALC_H:
    - If recenter_pend: nh = HC.
    - Else if run=0: nh = hbegin.
    - Else if h_dir=1: if hbegin + STEP >= HMAX then nh = HMAX and h_dir <= 0; else nh = hbegin + STEP.
    - Else (h_dir=0): if hbegin <= STEP then nh = 0 and h_dir <= 1; else nh = hbegin - STEP.
  - CALC_V: same rules as CALC_H with VMAX, VC, vbegin, v_dir.
  - COMMIT: `img_disp_hbegin`/`img_disp_vbegin` <= nh/nv, `pos_update` = 1 for this cycle, recenter_pend cleared if it was used; return to IDLE.
- Latency: outputs change exactly 3 clk_ctrl cycles after the accepted `frame_begin` edge (enter CALC_H, CALC_V, COMMIT).
- Outputs are held at all other times.
- Only the two internal registers nh and nv change before COMMIT, so no intermediate position is ever visible on the outputs.
- `frame_begin` arriving while not in IDLE is ignored and not counted.
- `recenter` arriving in the same cycle as CALC_H is used in that update. Directions are unchanged on recenter.
- If HMAX=0 (or VMAX=0), that axis stays at 0 and its direction does not toggle.
- Arithmetic is 16-bit unsigned. Comparisons use a 17-bit sum so that hbegin + STEP cannot wrap.
- Positions always satisfy 0 <= hbegin <= HMAX and 0 <= vbegin <= VMAX.

Optional Feature:
- Macro EDGE_HIT_CNT_EN.
- Defined:
  - `edge_hit_cnt` increments by 1 at COMMIT for each axis that toggled direction in that update (+2 on a corner hit).
  - Saturates at 16'hFFFF.
  - Cleared on reset only.
- Not defined: `edge_hit_cnt` is driven constant 0 and no counter logic is built.

Test Plan:
- Reset with defaults -> hbegin=300, vbegin=140, h_dir=v_dir=1, pos_update=0 held through 10 frame_begin pulses with run=0 (pos_update still pulses each frame, position unchanged).
- run=1, STEP=4, FRAME_DIV=1, one frame_begin -> 3 cycles later hbegin=304, vbegin=144, single pos_update pulse.
- Start hbegin=598 (via frames), h_dir=1, next update -> hbegin=600, h_dir=0. Next update -> 596. EDGE_HIT_CNT_EN: count +1.
- Position (2,2) with dirs 0/0 -> next update (0,0), both dirs 1. EDGE_HIT_CNT_EN: count +2.
- FRAME_DIV=3, run=1 -> position changes only on every 3rd frame_begin. A second frame_begin 1 cycle after an accepted one is ignored.
- recenter pulsed mid-frame while at (520,40) -> next update gives (300,140). rst=0 asserted in CALC_V -> all outputs return to reset values on the next edge.
